// File: rtl/axi_io_pmp_err_slv_if.sv
// axi_io_pmp_err_slv_if: AXI channel bundle between the IO-PMP deny path and the error slave
interface axi_io_pmp_err_slv_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 8,
  parameter int BUSER_WIDTH = 1,
  parameter int RUSER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]    s_axi_awid;
  logic [7:0]             s_axi_awlen;
  logic                   s_axi_awvalid;
  logic                   s_axi_awready;
  logic                   s_axi_wlast;
  logic                   s_axi_wvalid;
  logic                   s_axi_wready;
  logic [ID_WIDTH-1:0]    s_axi_bid;
  logic [1:0]             s_axi_bresp;
  logic [BUSER_WIDTH-1:0] s_axi_buser;
  logic                   s_axi_bvalid;
  logic                   s_axi_bready;
  logic [ID_WIDTH-1:0]    s_axi_arid;
  logic [7:0]             s_axi_arlen;
  logic                   s_axi_arvalid;
  logic                   s_axi_arready;
  logic [ID_WIDTH-1:0]    s_axi_rid;
  logic [DATA_WIDTH-1:0]  s_axi_rdata;
  logic [1:0]             s_axi_rresp;
  logic                   s_axi_rlast;
  logic [RUSER_WIDTH-1:0] s_axi_ruser;
  logic                   s_axi_rvalid;
  logic                   s_axi_rready;
  modport slave (
    input  s_axi_awid, s_axi_awlen, s_axi_awvalid, s_axi_wlast, s_axi_wvalid, s_axi_bready,
           s_axi_arid, s_axi_arlen, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_buser, s_axi_bvalid,
           s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid
  );
  modport master (
    output s_axi_awid, s_axi_awlen, s_axi_awvalid, s_axi_wlast, s_axi_wvalid, s_axi_bready,
           s_axi_arid, s_axi_arlen, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_buser, s_axi_bvalid,
           s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid
  );
endinterface

// File: rtl/axi_io_pmp_err_slv.sv
// axi_io_pmp_err_slv: terminates denied AXI transactions with an error response
module axi_io_pmp_err_slv #(
  parameter int         DATA_WIDTH  = 64,
  parameter int         ID_WIDTH    = 8,
  parameter int         BUSER_WIDTH = 1,
  parameter int         RUSER_WIDTH = 1,
  parameter logic [1:0] ERR_RESP    = 2'b10
) (
  input logic clk,
  input logic rst,
  axi_io_pmp_err_slv_if.slave s
);
  // A dedicated reset state keeps every registered output low while rst is held
  // and steps to idle on the first edge after release.
  localparam logic [1:0] W_RST = 2'd0, W_IDLE = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;
  localparam logic [1:0] R_RST = 2'd0, R_IDLE = 2'd1, R_DATA = 2'd2;
  logic [1:0]          w_state, r_state;
  logic [ID_WIDTH-1:0] w_id, r_id;
  logic [7:0]          w_len, w_cnt, r_len, r_cnt;
  logic                unused_wlast;
  assign unused_wlast = s.s_axi_wlast;
  // write path: accept AW, swallow awlen+1 beats counted against awlen, return one B
  always_ff @(posedge clk)
    if (rst) begin
      w_state <= W_RST;
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
    end else
      case (w_state)
        W_RST:  w_state <= W_IDLE;
        W_IDLE: if (s.s_axi_awvalid) begin
          w_state <= W_DATA;
          w_id    <= s.s_axi_awid;
          w_len   <= s.s_axi_awlen;
          w_cnt   <= '0;
        end
        W_DATA: if (s.s_axi_wvalid) begin
          w_cnt <= w_cnt + 8'd1;
          if (w_cnt == w_len) w_state <= W_RESP;
        end
        default: if (s.s_axi_bready) w_state <= W_IDLE;
      endcase
  // read path: accept AR, emit arlen+1 zero-data error beats
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= R_RST;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else
      case (r_state)
        R_RST:  r_state <= R_IDLE;
        R_IDLE: if (s.s_axi_arvalid) begin
          r_state <= R_DATA;
          r_id    <= s.s_axi_arid;
          r_len   <= s.s_axi_arlen;
          r_cnt   <= '0;
        end
        R_DATA: if (s.s_axi_rready) begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == r_len) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
  // all outputs decode purely from registered state
  always_comb begin
    s.s_axi_awready = w_state == W_IDLE;
    s.s_axi_wready  = w_state == W_DATA;
    s.s_axi_bvalid  = w_state == W_RESP;
    s.s_axi_bid     = s.s_axi_bvalid ? w_id : '0;
    s.s_axi_bresp   = s.s_axi_bvalid ? ERR_RESP : 2'b00;
    s.s_axi_buser   = '0;
    s.s_axi_arready = r_state == R_IDLE;
    s.s_axi_rvalid  = r_state == R_DATA;
    s.s_axi_rlast   = s.s_axi_rvalid && (r_cnt == r_len);
    s.s_axi_rid     = s.s_axi_rvalid ? r_id : '0;
    s.s_axi_rresp   = s.s_axi_rvalid ? ERR_RESP : 2'b00;
    s.s_axi_rdata   = '0;
    s.s_axi_ruser   = '0;
  end
endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
// tb_axi_io_pmp_err_slv: scoreboard bench for the IO-PMP error slave
module tb_axi_io_pmp_err_slv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_io_pmp_err_slv_if bus ();
  axi_io_pmp_err_slv dut (.clk(clk), .rst(rst), .s(bus));
  int checks = 0, errors = 0, cyc = 0;
  int rhs = 0, whs = 0, awhs = 0, arhs = 0, bstall = 0;
  int ar_cyc = 0, aw_cyc = 0, b_cyc = 0, r_first_cyc = 0, r_last_cyc = 0;
  bit rpend = 0, rmode = 0;
  logic [7:0] bq[$];
  logic [8:0] rq[$];
  logic pr_stall = 1'b0, pb_stall = 1'b0, p_rlast = 1'b0;
  logic [7:0] p_rid = '0, p_bid = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask
  // monitor: pops the scoreboard on every handshake seen just before the rising edge
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (pr_stall && bus.s_axi_rvalid !== 1'b1) fail("r_valid_dropped");
    else if (pr_stall) begin
      chk("r_hold_id", bus.s_axi_rid, p_rid);
      chk("r_hold_last", bus.s_axi_rlast, p_rlast);
    end
    if (pb_stall && bus.s_axi_bvalid !== 1'b1) fail("b_valid_dropped");
    else if (pb_stall) chk("b_hold_id", bus.s_axi_bid, p_bid);
    pr_stall = bus.s_axi_rvalid === 1'b1 && bus.s_axi_rready === 1'b0 && !rst;
    pb_stall = bus.s_axi_bvalid === 1'b1 && bus.s_axi_bready === 1'b0 && !rst;
    p_rid = bus.s_axi_rid;
    p_rlast = bus.s_axi_rlast;
    p_bid = bus.s_axi_bid;
    if (bus.s_axi_bvalid === 1'b1 && bus.s_axi_bready === 1'b0) bstall++;
    if (bus.s_axi_rvalid === 1'b1 && bus.s_axi_rready === 1'b1) begin
      rhs++;
      r_last_cyc = cyc;
      if (rpend) r_first_cyc = cyc;
      rpend = 0;
      if (rq.size() == 0) fail("r_unexpected");
      else begin
        e = rq.pop_front();
        chk("rid", bus.s_axi_rid, e[7:0]);
        chk("rlast", bus.s_axi_rlast, e[8]);
        chk("rdata", bus.s_axi_rdata, 0);
        chk("rresp", bus.s_axi_rresp, 2'b10);
        chk("ruser", bus.s_axi_ruser, 0);
      end
    end
    if (bus.s_axi_bvalid === 1'b1 && bus.s_axi_bready === 1'b1) begin
      b_cyc = cyc;
      if (bq.size() == 0) fail("b_unexpected");
      else begin
        chk("bid", bus.s_axi_bid, bq.pop_front());
        chk("bresp", bus.s_axi_bresp, 2'b10);
        chk("buser", bus.s_axi_buser, 0);
      end
    end
    if (bus.s_axi_wvalid === 1'b1 && bus.s_axi_wready === 1'b1) whs++;
    if (bus.s_axi_awvalid === 1'b1 && bus.s_axi_awready === 1'b1) begin
      awhs++;
      aw_cyc = cyc;
    end
    if (bus.s_axi_arvalid === 1'b1 && bus.s_axi_arready === 1'b1) begin
      arhs++;
      ar_cyc = cyc;
      rpend = 1;
    end
  end
  // rready pattern 1,0,0 repeating while rmode is set
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rmode) begin
        bus.s_axi_rready = (k % 3) == 0;
        k++;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  function automatic logic rdy(input int w);
    return w == 0 ? bus.s_axi_awready : w == 1 ? bus.s_axi_wready : bus.s_axi_arready;
  endfunction
  task automatic wait_rdy(input int w);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (rdy(w) !== 1'b1 && t < 2000);
    if (t >= 2000) fail("ready_timeout");
    @(posedge clk);
    #1;
  endtask
  task automatic wait_r(input int tgt);
    int t = 0;
    while (rhs < tgt && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (rhs < tgt) fail("r_timeout");
  endtask
  task automatic wait_empty();
    int t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (bq.size() != 0 || rq.size() != 0) fail("drain_timeout");
  endtask
  task automatic do_write(input logic [7:0] id, input logic [7:0] len, input int bad);
    bus.s_axi_awid = id;
    bus.s_axi_awlen = len;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid = 1'b1;
    bus.s_axi_wlast = 1'b0;
    bq.push_back(id);
    wait_rdy(0);
    bus.s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.s_axi_wlast = (i == int'(len)) ^ (i == bad);
      wait_rdy(1);
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast = 1'b0;
  endtask
  task automatic do_read(input logic [7:0] id, input logic [7:0] len);
    int tgt;
    bus.s_axi_arid = id;
    bus.s_axi_arlen = len;
    bus.s_axi_arvalid = 1'b1;
    for (int i = 0; i <= int'(len); i++) rq.push_back({i == int'(len), id});
    tgt = rhs + int'(len) + 1;
    wait_rdy(2);
    bus.s_axi_arvalid = 1'b0;
    wait_r(tgt);
  endtask
  initial begin
    int lr;
    bus.s_axi_awid = '0;
    bus.s_axi_awlen = '0;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wlast = 1'b0;
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b1;
    bus.s_axi_arid = '0;
    bus.s_axi_arlen = '0;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_arready,
                       bus.s_axi_rvalid, bus.s_axi_rlast, bus.s_axi_bid, bus.s_axi_rid,
                       bus.s_axi_bresp, bus.s_axi_rresp, bus.s_axi_buser, bus.s_axi_ruser}, 0);
      chk("rst_rdata", bus.s_axi_rdata, 0);
    end
    rst = 1'b0;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("release_ready", {bus.s_axi_awready, bus.s_axi_arready}, 2'b11);
    chk("rst_no_hs", awhs + arhs, 0);
    @(posedge clk);
    #1;
    do_write(8'h5A, 8'd3, -1);
    wait_empty();
    chk("w_beats_a", whs, 4);
    do_write(8'h5C, 8'd3, 1);
    wait_empty();
    chk("w_beats_b", whs, 8);
    do_read(8'h13, 8'd7);
    chk("r_first_lat", r_first_cyc - ar_cyc, 1);
    chk("r_burst_span", r_last_cyc - r_first_cyc, 7);
    lr = r_last_cyc;
    do_read(8'h14, 8'd0);
    chk("ar_bubble", ar_cyc - lr, 1);
    bus.s_axi_bready = 1'b0;
    bstall = 0;
    rmode = 1;
    fork
      do_read(8'h31, 8'd2);
      begin
        do_write(8'h41, 8'd0, -1);
        repeat (5) @(posedge clk);
        #1;
        bus.s_axi_bready = 1'b1;
      end
    join
    wait_empty();
    chk("b_stall_cycles", bstall, 5);
    rmode = 0;
    @(posedge clk);
    #3;
    bus.s_axi_rready = 1'b1;
    fork
      do_write(8'hA1, 8'd255, -1);
      do_read(8'h22, 8'd0);
    join
    chk("aw_ar_same_cycle", aw_cyc - ar_cyc, 0);
    do_write(8'hA2, 8'd0, -1);
    chk("aw_after_b", aw_cyc - b_cyc, 1);
    wait_empty();
    chk("w_beats_total", whs, 266);
    bus.s_axi_arid = 8'h66;
    bus.s_axi_arlen = 8'd4;
    bus.s_axi_arvalid = 1'b1;
    rq.push_back({1'b0, 8'h66});
    rq.push_back({1'b0, 8'h66});
    lr = rhs + 2;
    wait_rdy(2);
    bus.s_axi_arvalid = 1'b0;
    wait_r(lr);
    rst = 1'b1;
    bus.s_axi_rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_rvalid", bus.s_axi_rvalid, 0);
    rst = 1'b0;
    bus.s_axi_rready = 1'b1;
    @(posedge clk);
    #1;
    do_read(8'h67, 8'd1);
    wait_empty();
    repeat (3) @(posedge clk);
    #1;
    chk("r_beats_total", rhs, 17);
    chk("rq_left", rq.size(), 0);
    chk("bq_left", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
